// File: rtl/jtag_register_bank.sv
// jtag_register_bank: register bank scanned through the JTAG data register path.
// A scan starts with a header (op, addr) followed by one or more register frames;
// the address auto-increments between frames so bursts cover consecutive registers.
// Optional build macro JTAG_REGISTER_BANK_PARITY_EN adds an even-parity bit to write frames.
module jtag_register_bank #(
    parameter int unsigned NUMBER_OF_REGISTERS = 16,
    parameter int unsigned REGISTER_SIZE = 32,
    parameter logic [NUMBER_OF_REGISTERS-1:0] READ_ONLY_MASK = '0,
    parameter logic [REGISTER_SIZE-1:0] RESET_VALUE = '0
) (
    input  logic iTCK,
    input  logic iRST,
    input  logic iTDI,
    input  logic iSTATE_CDR,
    input  logic iSTATE_SDR,
    input  logic iSTATE_UDR,
    output logic oTDO,
    input  logic [NUMBER_OF_REGISTERS-1:0][REGISTER_SIZE-1:0] iDATA,
    output logic [NUMBER_OF_REGISTERS-1:0][REGISTER_SIZE-1:0] oDATA,
    output logic [NUMBER_OF_REGISTERS-1:0] oWRITE_STROBE,
    output logic oPARITY_ERR
);

    localparam int unsigned AW = (NUMBER_OF_REGISTERS > 1) ? $clog2(NUMBER_OF_REGISTERS) : 1;
    localparam int unsigned H = 2 + AW;
`ifdef JTAG_REGISTER_BANK_PARITY_EN
    localparam bit ParityEn = 1'b1;
`else
    localparam bit ParityEn = 1'b0;
`endif
    // Shift register holds one extra bit when write frames carry parity.
    localparam int unsigned SW = REGISTER_SIZE + (ParityEn ? 1 : 0);
    localparam int unsigned CW = 9;

    localparam logic [1:0] OpId    = 2'b00;
    localparam logic [1:0] OpRead  = 2'b01;
    localparam logic [1:0] OpWrite = 2'b10;
    localparam logic [1:0] OpExch  = 2'b11;

    // ID word {size, count}, zero-extended (or truncated) to the shift register width.
    localparam logic [SW+15:0] IdWide = {{SW{1'b0}}, 8'(REGISTER_SIZE), 8'(NUMBER_OF_REGISTERS)};

    typedef enum logic [1:0] {StIdle, StHeader, StData} state_e;

    state_e state_q, state_d;
    logic [SW-1:0] sr_q, sr_d;
    logic [H-1:0] hdr_q, hdr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0] op_q, op_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [NUMBER_OF_REGISTERS-1:0][REGISTER_SIZE-1:0] data_q, data_d;
    logic [NUMBER_OF_REGISTERS-1:0] strobe_q, strobe_d;
    logic perr_q, perr_d;

    logic [SW-1:0] shifted;
    logic [H-1:0] hdr_shifted;
    logic [AW-1:0] next_addr;
    logic [CW-1:0] frame_len;
    logic in_range;

    // Word loaded into the shift register at the start of a frame.
    function automatic logic [SW-1:0] load_word(
        input logic [1:0] op,
        input logic [AW-1:0] a,
        input logic first,
        input logic [NUMBER_OF_REGISTERS-1:0][REGISTER_SIZE-1:0] bus
    );
        logic [SW-1:0] w;
        w = '0;
        case (op)
            OpId: if (first) w = IdWide[SW-1:0];
            OpRead, OpExch: if (32'(a) < NUMBER_OF_REGISTERS) w = SW'(bus[a]);
            default: w = '0;
        endcase
        return w;
    endfunction

    // Next-state logic: TAP flag decode (CDR > SDR > UDR), header capture, frame handling.
    always_comb begin
        state_d  = state_q;
        sr_d     = sr_q;
        hdr_d    = hdr_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        addr_d   = addr_q;
        data_d   = data_q;
        strobe_d = '0;
        perr_d   = perr_q;

        shifted     = {iTDI, sr_q[SW-1:1]};
        hdr_shifted = {iTDI, hdr_q[H-1:1]};
        in_range    = 32'(addr_q) < NUMBER_OF_REGISTERS;
        frame_len   = (ParityEn && op_q[1]) ? CW'(SW) : CW'(REGISTER_SIZE);

        // Wrap at the last register; an out-of-range address parks where it is.
        if (32'(addr_q) == NUMBER_OF_REGISTERS - 1) begin
            next_addr = '0;
        end else if (!in_range) begin
            next_addr = addr_q;
        end else begin
            next_addr = addr_q + 1'b1;
        end

        if (iSTATE_CDR) begin
            state_d = StHeader;
            cnt_d   = '0;
            sr_d    = '0;
            hdr_d   = '0;
            perr_d  = 1'b0;
        end else if (iSTATE_SDR) begin
            case (state_q)
                StHeader: begin
                    hdr_d = hdr_shifted;
                    if (cnt_q == CW'(H - 1)) begin
                        state_d = StData;
                        cnt_d   = '0;
                        op_d    = hdr_shifted[1:0];
                        addr_d  = hdr_shifted[H-1:2];
                        sr_d    = load_word(hdr_shifted[1:0], hdr_shifted[H-1:2], 1'b1, iDATA);
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                StData: begin
                    sr_d  = shifted;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == frame_len - CW'(1)) begin
                        cnt_d = '0;
                        if (op_q[1]) begin
                            // Even parity: data plus parity bit must XOR to zero.
                            if (ParityEn && (^shifted)) begin
                                perr_d = 1'b1;
                            end else if (in_range && !READ_ONLY_MASK[addr_q]) begin
                                data_d[addr_q]   = shifted[REGISTER_SIZE-1:0];
                                strobe_d[addr_q] = 1'b1;
                            end
                        end
                        addr_d = next_addr;
                        sr_d   = load_word(op_q, next_addr, 1'b0, iDATA);
                    end
                end
                default: ;
            endcase
        end else if (iSTATE_UDR) begin
            state_d = StIdle;
        end
    end

    // State register with asynchronous reset back to idle and reset register contents.
    always_ff @(posedge iTCK or posedge iRST) begin
        if (iRST) begin
            state_q  <= StIdle;
            sr_q     <= '0;
            hdr_q    <= '0;
            cnt_q    <= '0;
            op_q     <= OpId;
            addr_q   <= '0;
            data_q   <= {NUMBER_OF_REGISTERS{RESET_VALUE}};
            strobe_q <= '0;
            perr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sr_q     <= sr_d;
            hdr_q    <= hdr_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            strobe_q <= strobe_d;
            perr_q   <= perr_d;
        end
    end

    assign oTDO          = (state_q == StData) ? sr_q[0] : 1'b0;
    assign oDATA         = data_q;
    assign oWRITE_STROBE = strobe_q;
    // Stays zero without the parity build since nothing can set it.
    assign oPARITY_ERR   = perr_q;

endmodule

// File: tb/tb_jtag_register_bank.sv
// Directed self-checking bench for jtag_register_bank (N=16, W=32, register 2 read-only).
module tb_jtag_register_bank;

    localparam int unsigned N = 16;
    localparam int unsigned W = 32;
    localparam logic [31:0] RV = 32'h0000_CAFE;
`ifdef JTAG_REGISTER_BANK_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic tck = 1'b0;
    logic rst, tdi, cdr, sdr, udr, tdo, perr;
    logic [N-1:0][W-1:0] idata, odata;
    logic [N-1:0] strobe;
    logic [63:0] got;
    int checks = 0;
    int errors = 0;

    jtag_register_bank #(
        .NUMBER_OF_REGISTERS(N),
        .REGISTER_SIZE(W),
        .READ_ONLY_MASK(16'h0004),
        .RESET_VALUE(RV)
    ) dut (
        .iTCK(tck),
        .iRST(rst),
        .iTDI(tdi),
        .iSTATE_CDR(cdr),
        .iSTATE_SDR(sdr),
        .iSTATE_UDR(udr),
        .oTDO(tdo),
        .iDATA(idata),
        .oDATA(odata),
        .oWRITE_STROBE(strobe),
        .oPARITY_ERR(perr)
    );

    always #5 tck = ~tck;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge tck);
        #1;
    endtask

    // Shift n bits LSB first, capturing oTDO before each edge.
    task automatic shift(input logic [63:0] val, input int n, output logic [63:0] out);
        out = '0;
        for (int i = 0; i < n; i++) begin
            tdi = val[i];
            sdr = 1'b1;
            out[i] = tdo;
            step();
        end
        sdr = 1'b0;
        tdi = 1'b0;
    endtask

    task automatic header(input logic [1:0] op, input logic [3:0] a);
        logic [63:0] dummy;
        cdr = 1'b1;
        step();
        cdr = 1'b0;
        shift({58'b0, a, op}, 6, dummy);
    endtask

    // Write frame: data plus parity bit in parity builds; bad flips the parity bit.
    task automatic frame(input logic [31:0] d, input bit bad, output logic [31:0] out);
        logic [63:0] o;
        logic p;
        p = (^d) ^ bad;
        shift({31'b0, p, d}, PAR ? 33 : 32, o);
        out = o[31:0];
    endtask

    task automatic update();
        udr = 1'b1;
        step();
        udr = 1'b0;
    endtask

    initial begin
        logic [31:0] o32;
        rst = 1'b1; tdi = 1'b0; cdr = 1'b0; sdr = 1'b0; udr = 1'b0;
        idata = '0;
        idata[5] = 32'hA5A5_0001;
        idata[6] = 32'h0000_0007;
        idata[9] = 32'h0BAD_F00D;
        repeat (2) step();

        check("rst_data0", odata[0], RV);
        check("rst_data15", odata[15], RV);
        check("rst_strobe", strobe, 0);
        check("rst_perr", perr, 0);
        check("rst_tdo", tdo, 0);
        rst = 1'b0;
        step();

        // Single write to register 3.
        cdr = 1'b1;
        step();
        cdr = 1'b0;
        check("hdr_tdo", tdo, 0);
        shift({58'b0, 4'd3, 2'b10}, 6, got);
        frame(32'hDEAD_BEEF, 1'b0, o32);
        check("wr3_data", odata[3], 32'hDEAD_BEEF);
        check("wr3_strobe", strobe, 16'h0008);
        update();
        check("wr3_strobe_off", strobe, 0);
        check("wr3_perr", perr, 0);

        // Burst write wrapping from 15 to 0 and 1.
        header(2'b10, 4'd15);
        frame(32'h11, 1'b0, o32);
        check("b15_strobe", strobe, 16'h8000);
        frame(32'h22, 1'b0, o32);
        check("b0_strobe", strobe, 16'h0001);
        frame(32'h33, 1'b0, o32);
        check("b1_strobe", strobe, 16'h0002);
        update();
        check("b15_data", odata[15], 32'h11);
        check("b0_data", odata[0], 32'h22);
        check("b1_data", odata[1], 32'h33);
        check("b_strobe_off", strobe, 0);

        // Burst read of registers 5 and 6.
        header(2'b01, 4'd5);
        shift(64'h0, 64, got);
        check("rd56", got, 64'h0000_0007_A5A5_0001);
        update();
        check("rd_strobe", strobe, 0);
        check("idle_tdo", tdo, 0);

        // ID readout, then zeros on the following frame.
        header(2'b00, 4'd0);
        shift(64'h0, 64, got);
        check("id", got, 64'h0000_0000_0000_2010);
        update();

        // Exchange: read old iDATA[9] while writing register 9.
        header(2'b11, 4'd9);
        frame(32'h600D_CAFE, 1'b0, o32);
        check("ex_rd", o32, 32'h0BAD_F00D);
        check("ex_data", odata[9], 32'h600D_CAFE);
        check("ex_strobe", strobe, 16'h0200);
        update();

        // Partial frame then UDR: nothing written.
        header(2'b10, 4'd7);
        shift(64'hF_FFFF, 20, got);
        update();
        check("part_data", odata[7], RV);
        check("part_strobe", strobe, 0);
        check("part_tdo", tdo, 0);

        // Read-only register 2.
        header(2'b10, 4'd2);
        frame(32'h1234_5678, 1'b0, o32);
        check("ro_data", odata[2], RV);
        check("ro_strobe", strobe, 0);
        update();

        // Bad parity on register 4 (written normally when parity is not built in).
        header(2'b10, 4'd4);
        frame(32'h0F0F_0F0F, 1'b1, o32);
        check("par_data", odata[4], PAR ? 64'(RV) : 64'h0F0F_0F0F);
        check("par_strobe", strobe, PAR ? 0 : 16'h0010);
        check("par_err", perr, PAR ? 1 : 0);
        update();
        step();
        check("par_sticky", perr, PAR ? 1 : 0);
        cdr = 1'b1;
        step();
        cdr = 1'b0;
        check("par_clear", perr, 0);
        update();

        // Reset while a write strobe is active in the middle of a burst.
        header(2'b10, 4'd8);
        frame(32'h55, 1'b0, o32);
        check("pre_rst_strobe", strobe, 16'h0100);
        check("pre_rst_data", odata[8], 32'h55);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_data8", odata[8], RV);
        check("mid_rst_data3", odata[3], RV);
        check("mid_rst_strobe", strobe, 0);
        check("mid_rst_tdo", tdo, 0);
        step();
        rst = 1'b0;
        step();
        shift(64'hFFFF_FFFF_FFFF_FFFF, 40, got);
        check("post_rst_tdo", got, 0);
        check("post_rst_data", odata[0], RV);
        check("post_rst_strobe", strobe, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/jtag_register_bank.md
Name: jtag_register_bank

Overview:
- JTAG-DR-scanned register bank; successor to the single-register memory block.
- Adds a command header, multi-register burst transfers with address auto-increment, per-register write strobes, a read-only mask and an ID readout.
- Sits behind the virtual-JTAG TAP decode; consumes its SDR/CDR/UDR state flags and TCK.
- All logic is clocked on TCK.

Parameters:
- NUMBER_OF_REGISTERS, 16, number of registers (1..255).
- REGISTER_SIZE, 32, bits per register (8..255).
- READ_ONLY_MASK, 0, NUMBER_OF_REGISTERS-bit mask; a set bit blocks JTAG writes to that register.
- RESET_VALUE, 0, REGISTER_SIZE-bit value loaded into every oDATA register on reset.
- Derived: AW = max(1, clog2(NUMBER_OF_REGISTERS)); header length H = 2 + AW.

Ports:
- iTCK  in  1  TCK clock.
- iRST  in  1  asynchronous, active-high reset.
- iTDI  in  1  serial data in.
- iSTATE_CDR  in  1  TAP in Capture-DR.
- iSTATE_SDR  in  1  TAP in Shift-DR.
- iSTATE_UDR  in  1  TAP in Update-DR.
- oTDO  out  1  serial data out.
- iDATA  in  NUMBER_OF_REGISTERS x REGISTER_SIZE  readback bus.
- oDATA  out  NUMBER_OF_REGISTERS x REGISTER_SIZE  register contents.
- oWRITE_STROBE  out  NUMBER_OF_REGISTERS  one-TCK pulse per written register.
- oPARITY_ERR  out  1  sticky parity error flag.

Behaviour:
- Clock and reset: one clock, iTCK; reset iRST is asynchronous, active-high. Flag priority is CDR > SDR > UDR.
- Reset values:
  - oDATA = RESET_VALUE for every register.
  - oWRITE_STROBE = 0; oPARITY_ERR = 0; oTDO = 0.
  - FSM = IDLE; shift register and counters = 0.
- FSM states: IDLE, HEADER, DATA.
  - Any state + CDR -> HEADER; bit counter, shift register and oPARITY_ERR cleared.
  - HEADER + SDR: shift iTDI in, LSB first. Header layout: op[1:0] in bits [1:0], addr in bits [H-1:2].
  - On the H-th SDR edge -> DATA. Latch op and addr.
  - Load the shift register: iDATA[addr] for op 01 or 11; ID word {8'REGISTER_SIZE, 8'NUMBER_OF_REGISTERS} zero-extended for op 00; zero for op 10.
  - Any state + UDR -> IDLE. A partially shifted frame is discarded; nothing is written.
- Op codes: 00 = ID, 01 = read, 10 = write, 11 = exchange (read and write the same address).
- oTDO: equals shiftreg[0] in DATA; 0 in IDLE and HEADER. Combinational from registers.
- DATA + SDR:
  - shiftreg <= {iTDI, shiftreg[W-1:1]}, where frame length W = REGISTER_SIZE.
  - Frame counter increments each edge.
- On the last bit of a frame (same edge):
  - Write ops (10, 11): if addr < NUMBER_OF_REGISTERS and READ_ONLY_MASK[addr] == 0, oDATA[addr] <= the completed frame and oWRITE_STROBE[addr] = 1 for the following TCK cycle. Otherwise the write is silently dropped with no strobe.
  - Address advance: if addr == NUMBER_OF_REGISTERS-1, addr wraps to 0. If addr is out of range, addr holds. Otherwise addr + 1.
  - Reload the shift register: iDATA[new addr] for ops 01 and 11; 0 for op 00 after the first frame; 0 for op 10.
- Out-of-range read: returns all zeros.
- oWRITE_STROBE is one-hot or zero; it is never high for more than one cycle per frame.
- Reset mid-scan: immediate return to IDLE; writes in progress are lost; oDATA returns to RESET_VALUE.

Optional Feature:
- Macro: JTAG_REGISTER_BANK_PARITY_EN.
- When defined:
  - Write frames are REGISTER_SIZE+1 bits; the extra MSB-side bit is even parity over the data.
  - On a parity mismatch the write is dropped, no strobe is issued, oPARITY_ERR is set, and addr still advances.
  - oPARITY_ERR is sticky until the next CDR or reset.
  - Read-only ops keep REGISTER_SIZE-bit frames.
- When undefined: frames are REGISTER_SIZE bits and oPARITY_ERR is tied to 0.

Test Plan:
1. Assert iRST mid-write-burst -> oDATA = RESET_VALUE immediately, FSM IDLE, oTDO = 0, no strobe.
2. N=16, W=32: CDR, header op=10 addr=3, frame 0xDEADBEEF, UDR -> oDATA[3] = 0xDEADBEEF; oWRITE_STROBE = 0x0008 for exactly one cycle.
3. Burst write op=10 addr=15 with frames 0x11, 0x22, 0x33 -> registers 15, 0, 1 written; strobes 0x8000, 0x0001, 0x0002 in order.
4. iDATA[5] = 0xA5A5_0001, iDATA[6] = 0x7; op=01 addr=5, shift 64 bits -> oTDO yields 0xA5A50001 then 0x00000007, LSB first.
5. op=00 with W=32, N=16 -> 32 bits out = 0x00002010; UDR after 20 bits -> no state change.
6. READ_ONLY_MASK = 0x0004, op=10 addr=2 -> oDATA[2] unchanged, no strobe. With parity enabled and a bad parity bit on addr 4 -> no write, oPARITY_ERR = 1 until next CDR.
